// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_port_arbiter : round-robin sharing of one memory read port between two
//                    cache fill requesters, with a per-grant response watchdog.
// Revision: 1.0
// ==========================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int WIDTH   = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             r0_enable,
  input  logic [WIDTH-1:0] r0_address,
  output logic             r0_data_valid,
  output logic [WIDTH-1:0] r0_data,
  output logic             r0_error,
  input  logic             r1_enable,
  input  logic [WIDTH-1:0] r1_address,
  output logic             r1_data_valid,
  output logic [WIDTH-1:0] r1_data,
  output logic             r1_error,
  output logic             mem_enable,
  output logic [WIDTH-1:0] mem_address,
  input  logic             mem_data_valid,
  input  logic [WIDTH-1:0] mem_data
);

  localparam int TIMER_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TIMER_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TIMER_MAX_I  = (TIMEOUT > 0) ? TIMEOUT : 0;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_LAST_I);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMER_MAX_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t             state;
  state_t             arb_next;
  logic               prio;
  logic [TIMER_W-1:0] timer;
  logic [WIDTH-1:0]   addr_q;

  logic owner;
  logic owner_en;
  logic rearb;
  logic arb_prio;
  logic abort;
  logic timeout_hit;

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      assign timeout_hit = (timer == TIMER_LAST);
    end else begin : g_no_watchdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign owner    = (state == GNT1);
  assign owner_en = owner ? r1_enable : r0_enable;

  // Decide whether this edge re-arbitrates, and which prio the tie-break uses.
  always_comb begin
    rearb    = 1'b0;
    arb_prio = prio;
    abort    = 1'b0;
    case (state)
      IDLE: rearb = 1'b1;
      GNT0, GNT1: begin
        if (mem_data_valid) begin
          rearb    = 1'b1;
          arb_prio = ~owner;
        end else if (!owner_en) begin
          rearb = 1'b1;
        end else if (timeout_hit) begin
          rearb    = 1'b1;
          arb_prio = ~owner;
          abort    = 1'b1;
        end
      end
      default: rearb = 1'b1;
    endcase
  end

  always_comb begin
    arb_next = IDLE;
    if (r0_enable && r1_enable) begin
      arb_next = arb_prio ? GNT1 : GNT0;
    end else if (r0_enable) begin
      arb_next = GNT0;
    end else if (r1_enable) begin
      arb_next = GNT1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      timer      <= '0;
      addr_q     <= '0;
      mem_enable <= 1'b0;
      r0_error   <= 1'b0;
      r1_error   <= 1'b0;
    end else begin
      r0_error <= abort && !owner;
      r1_error <= abort && owner;
      if (rearb) begin
        state      <= arb_next;
        prio       <= arb_prio;
        mem_enable <= (arb_next != IDLE);
        timer      <= '0;
        if (arb_next == GNT0) begin
          addr_q <= r0_address;
        end else if (arb_next == GNT1) begin
          addr_q <= r1_address;
        end
      end else if (timer != TIMER_MAX) begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

  // Data is shared; only the valid strobe is steered to the granted requester.
  assign mem_address   = addr_q;
  assign r0_data       = mem_data;
  assign r1_data       = mem_data;
  assign r0_data_valid = mem_data_valid && r0_enable && (state == GNT0);
  assign r1_data_valid = mem_data_valid && r1_enable && (state == GNT1);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Directed bench for mem_port_arbiter (TIMEOUT=4): reset, single read,
// contention, watchdog, abandon and the completion/timeout race.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        r0_enable, r1_enable;
  logic [31:0] r0_address, r1_address;
  logic        r0_data_valid, r1_data_valid;
  logic [31:0] r0_data, r1_data;
  logic        r0_error, r1_error;
  logic        mem_enable;
  logic [31:0] mem_address;
  logic        mem_data_valid;
  logic [31:0] mem_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.TIMEOUT(4), .WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .r0_enable      (r0_enable),
    .r0_address     (r0_address),
    .r0_data_valid  (r0_data_valid),
    .r0_data        (r0_data),
    .r0_error       (r0_error),
    .r1_enable      (r1_enable),
    .r1_address     (r1_address),
    .r1_data_valid  (r1_data_valid),
    .r1_data        (r1_data),
    .r1_error       (r1_error),
    .mem_enable     (mem_enable),
    .mem_address    (mem_address),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "bench did not finish");
  end

  logic [31:0] seq_addr [4];
  initial begin
    seq_addr[0] = 32'h10;
    seq_addr[1] = 32'h20;
    seq_addr[2] = 32'h10;
    seq_addr[3] = 32'h20;
  end

  initial begin
    reset_n        = 1'b0;
    r0_enable      = 1'b1;
    r1_enable      = 1'b0;
    r0_address     = 32'h0;
    r1_address     = 32'h0;
    mem_data_valid = 1'b0;
    mem_data       = 32'h0;

    // Reset held two edges with r0 requesting
    tick();
    tick();
    #1;
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_r0_valid", {31'd0, r0_data_valid}, 32'd0);
    check("rst_errors", {30'd0, r1_error, r0_error}, 32'd0);
    reset_n    = 1'b1;
    r0_address = 32'h100;

    // Single read: grant one cycle after release, reply on third cycle after
    tick();
    #1;
    check("single_grant_en", {31'd0, mem_enable}, 32'd1);
    check("single_grant_addr", mem_address, 32'h100);
    tick();
    #1;
    check("single_wait_valid", {31'd0, r0_data_valid}, 32'd0);
    tick();
    mem_data_valid = 1'b1;
    mem_data       = 32'hDEADBEEF;
    #1;
    check("single_r0_valid", {31'd0, r0_data_valid}, 32'd1);
    check("single_r0_data", r0_data, 32'hDEADBEEF);
    check("single_r1_valid", {31'd0, r1_data_valid}, 32'd0);
    // r0 still requesting at completion, so it is re-granted; drop it now
    tick();
    mem_data_valid = 1'b0;
    r0_enable      = 1'b0;
    #1;
    check("single_once_valid", {31'd0, r0_data_valid}, 32'd0);
    tick();
    #1;
    check("single_release_en", {31'd0, mem_enable}, 32'd0);

    // Contention from reset: strict alternation with no idle cycle
    reset_n    = 1'b0;
    r0_enable  = 1'b1;
    r1_enable  = 1'b1;
    r0_address = 32'h10;
    r1_address = 32'h20;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_data_valid = 1'b0;
      #1;
      check($sformatf("cont_en_%0d", i), {31'd0, mem_enable}, 32'd1);
      check($sformatf("cont_addr_%0d", i), mem_address, seq_addr[i]);
      tick();
      mem_data_valid = 1'b1;
      mem_data       = 32'hA0 + i;
      #1;
      check($sformatf("cont_valid_%0d", i), {30'd0, r1_data_valid, r0_data_valid},
            (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Watchdog: r1 granted, memory silent, r0 pending
    tick();
    mem_data_valid = 1'b0;
    reset_n        = 1'b0;
    r0_enable      = 1'b0;
    r1_enable      = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    r0_enable = 1'b1;
    #1;
    check("wd_grant_addr", mem_address, 32'h20);
    tick();
    tick();
    tick();
    #1;
    check("wd_no_early_err", {30'd0, r1_error, r0_error}, 32'd0);
    tick();
    #1;
    check("wd_r1_error", {30'd0, r1_error, r0_error}, 32'd2);
    check("wd_next_addr", mem_address, 32'h10);
    check("wd_next_en", {31'd0, mem_enable}, 32'd1);
    tick();
    #1;
    check("wd_pulse_once", {30'd0, r1_error, r0_error}, 32'd0);

    // Abandon: r0 drops before any reply
    r0_enable = 1'b0;
    r1_enable = 1'b0;
    tick();
    #1;
    check("abandon_en", {31'd0, mem_enable}, 32'd0);
    check("abandon_err", {30'd0, r1_error, r0_error}, 32'd0);
    r0_enable      = 1'b1;
    r1_enable      = 1'b1;
    mem_data_valid = 1'b1;
    #1;
    check("abandon_late_valid", {30'd0, r1_data_valid, r0_data_valid}, 32'd0);

    // Tie after abandon resolves with prio still 0; then reply on the timeout cycle
    tick();
    mem_data_valid = 1'b0;
    #1;
    check("abandon_prio", mem_address, 32'h10);
    tick();
    tick();
    tick();
    mem_data_valid = 1'b1;
    mem_data       = 32'hCAFEF00D;
    #1;
    check("race_valid", {30'd0, r1_data_valid, r0_data_valid}, 32'd1);
    check("race_data", r0_data, 32'hCAFEF00D);
    tick();
    mem_data_valid = 1'b0;
    #1;
    check("race_no_error", {30'd0, r1_error, r0_error}, 32'd0);
    check("race_next_addr", mem_address, 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
